multi_cycle_control: RTL and testbench

Main control FSM for the multi-cycle variant of the MIPS core. It sequences the shared ALU, memory port, IR, PC and register file across FETCH/DECODE/EXECUTE/MEM/WB states. It drives the 2-bit ALUOp consumed by ALU_Control, plus a function-code override so that addi/andi/ori reuse the R-type ALU decode. Supported instructions: add, sub, and, or, slt, addi, andi, ori, lw, sw, beq, j. Memory has variable latency, so every memory state handshakes on mem_ready.

---
 rtl/mips_ctrl_pkg.sv | 68 ++++++
 rtl/multi_cycle_control.sv | 176 +++++++++++++++++
 tb/tb_multi_cycle_control.sv | 183 ++++++++++++++++++
 3 files changed

// File: rtl/mips_ctrl_pkg.sv
// Shared definitions for the multi-cycle MIPS control path: state encodings,
// opcode and funct constants, ALUOp codes and datapath mux select values.
package mips_ctrl_pkg;

  localparam int OP_W_DEF = 6;

  typedef enum logic [3:0] {
    ST_FETCH    = 4'd0,
    ST_DECODE   = 4'd1,
    ST_MEM_ADDR = 4'd2,
    ST_MEM_RD   = 4'd3,
    ST_MEM_WB   = 4'd4,
    ST_MEM_WR   = 4'd5,
    ST_R_EXEC   = 4'd6,
    ST_R_WB     = 4'd7,
    ST_BRANCH   = 4'd8,
    ST_JUMP     = 4'd9,
    ST_I_EXEC   = 4'd10,
    ST_I_WB     = 4'd11
  } state_t;

  // Opcodes (IR[31:26])
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_ANDI  = 6'b001100;
  localparam logic [5:0] OP_ORI   = 6'b001101;

  // ALUOp codes consumed by ALU_Control
  localparam logic [1:0] ALUOP_ADD   = 2'b00;
  localparam logic [1:0] ALUOP_SUB   = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT = 2'b10;

  // R-type funct codes
  localparam logic [5:0] FUNCT_ADD = 6'b100000;
  localparam logic [5:0] FUNCT_SUB = 6'b100010;
  localparam logic [5:0] FUNCT_AND = 6'b100100;
  localparam logic [5:0] FUNCT_OR  = 6'b100101;
  localparam logic [5:0] FUNCT_SLT = 6'b101010;

  // ALU B-input select
  localparam logic [1:0] SRCB_REG    = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  // PC source select
  localparam logic [1:0] PCSRC_ALU    = 2'b00;
  localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
  localparam logic [1:0] PCSRC_JUMP   = 2'b10;

  // Immediate ALU ops borrow the matching R-type funct so ALU_Control
  // needs no separate immediate decode.
  function automatic logic [5:0] imm_funct(input logic [5:0] op);
    logic [5:0] f;
    f = FUNCT_ADD;
    case (op)
      OP_ANDI: f = FUNCT_AND;
      OP_ORI:  f = FUNCT_OR;
      default: f = FUNCT_ADD;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/multi_cycle_control.sv
// Main control FSM of the multi-cycle MIPS core. Moore outputs are decoded
// from the registered state; memory states handshake on mem_ready.
module multi_cycle_control
  import mips_ctrl_pkg::*;
#(
  parameter int RET_CNT_W = 32,
  parameter int OP_W      = OP_W_DEF
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [OP_W-1:0]      opcode,
  input  logic                 mem_ready,
  output logic                 pc_write,
  output logic                 pc_write_cond,
  output logic                 i_or_d,
  output logic                 mem_read,
  output logic                 mem_write,
  output logic                 ir_write,
  output logic                 mem_to_reg,
  output logic                 reg_dst,
  output logic                 reg_write,
  output logic                 alu_src_a,
  output logic [1:0]           alu_src_b,
  output logic [1:0]           alu_op,
  output logic                 funct_ovr_en,
  output logic [5:0]           funct_ovr,
  output logic [1:0]           pc_source,
  output logic [3:0]           state_o,
  output logic                 illegal_op,
  output logic [RET_CNT_W-1:0] instr_retired
);

  localparam logic [RET_CNT_W-1:0] RET_ONE = {{(RET_CNT_W-1){1'b0}}, 1'b1};

  state_t               state_q, state_d;
  logic [RET_CNT_W-1:0] retired_q, retired_d;
  logic                 illegal_q, illegal_d;

  // Write/request strobes before the reset gate
  logic pc_write_raw, pc_write_cond_raw, mem_read_raw, mem_write_raw;
  logic ir_write_raw, reg_write_raw;
  logic retire;

  // State, retired counter and illegal-op pulse registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= ST_FETCH;
      retired_q <= '0;
      illegal_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      retired_q <= retired_d;
      illegal_q <= illegal_d;
    end
  end

  // Next-state and Moore output decode
  always_comb begin
    state_d           = ST_FETCH;
    illegal_d         = 1'b0;
    retire            = 1'b0;
    pc_write_raw      = 1'b0;
    pc_write_cond_raw = 1'b0;
    mem_read_raw      = 1'b0;
    mem_write_raw     = 1'b0;
    ir_write_raw      = 1'b0;
    reg_write_raw     = 1'b0;
    i_or_d            = 1'b0;
    mem_to_reg        = 1'b0;
    reg_dst           = 1'b0;
    alu_src_a         = 1'b0;
    alu_src_b         = SRCB_REG;
    alu_op            = ALUOP_ADD;
    funct_ovr_en      = 1'b0;
    funct_ovr         = 6'b000000;
    pc_source         = PCSRC_ALU;

    case (state_q)
      ST_FETCH: begin
        mem_read_raw = 1'b1;
        alu_src_b    = SRCB_FOUR;
        // IR and PC+4 commit only on the cycle the instruction word arrives
        ir_write_raw = mem_ready;
        pc_write_raw = mem_ready;
        state_d      = mem_ready ? ST_DECODE : ST_FETCH;
      end
      ST_DECODE: begin
        // Precompute the branch target into ALUOut while decoding
        alu_src_b = SRCB_IMM_SH;
        case (opcode)
          OP_RTYPE:                 state_d = ST_R_EXEC;
          OP_LW, OP_SW:             state_d = ST_MEM_ADDR;
          OP_BEQ:                   state_d = ST_BRANCH;
          OP_J:                     state_d = ST_JUMP;
          OP_ADDI, OP_ANDI, OP_ORI: state_d = ST_I_EXEC;
          default: begin
            state_d   = ST_FETCH;
            illegal_d = 1'b1;
          end
        endcase
      end
      ST_MEM_ADDR: begin
        alu_src_a = 1'b1;
        alu_src_b = SRCB_IMM;
        state_d   = (opcode == OP_LW) ? ST_MEM_RD : ST_MEM_WR;
      end
      ST_MEM_RD: begin
        mem_read_raw = 1'b1;
        i_or_d       = 1'b1;
        state_d      = mem_ready ? ST_MEM_WB : ST_MEM_RD;
      end
      ST_MEM_WB: begin
        reg_write_raw = 1'b1;
        mem_to_reg    = 1'b1;
        retire        = 1'b1;
      end
      ST_MEM_WR: begin
        mem_write_raw = 1'b1;
        i_or_d        = 1'b1;
        retire        = mem_ready;
        state_d       = mem_ready ? ST_FETCH : ST_MEM_WR;
      end
      ST_R_EXEC: begin
        alu_src_a = 1'b1;
        alu_op    = ALUOP_FUNCT;
        state_d   = ST_R_WB;
      end
      ST_R_WB: begin
        reg_write_raw = 1'b1;
        reg_dst       = 1'b1;
        retire        = 1'b1;
      end
      ST_I_EXEC: begin
        alu_src_a    = 1'b1;
        alu_src_b    = SRCB_IMM;
        alu_op       = ALUOP_FUNCT;
        funct_ovr_en = 1'b1;
        funct_ovr    = imm_funct(opcode[5:0]);
        state_d      = ST_I_WB;
      end
      ST_I_WB: begin
        reg_write_raw = 1'b1;
        retire        = 1'b1;
      end
      ST_BRANCH: begin
        alu_src_a         = 1'b1;
        alu_op            = ALUOP_SUB;
        pc_write_cond_raw = 1'b1;
        pc_source         = PCSRC_ALUOUT;
        retire            = 1'b1;
      end
      ST_JUMP: begin
        pc_write_raw = 1'b1;
        pc_source    = PCSRC_JUMP;
        retire       = 1'b1;
      end
      default: state_d = ST_FETCH;
    endcase

    retired_d = retire ? (retired_q + RET_ONE) : retired_q;
  end

  // Reset suppresses every architectural write immediately, so an
  // instruction abandoned mid-flight leaves no side effects.
  assign pc_write      = pc_write_raw      & ~rst;
  assign pc_write_cond = pc_write_cond_raw & ~rst;
  assign mem_read      = mem_read_raw      & ~rst;
  assign mem_write     = mem_write_raw     & ~rst;
  assign ir_write      = ir_write_raw      & ~rst;
  assign reg_write     = reg_write_raw     & ~rst;

  assign state_o       = state_q;
  assign illegal_op    = illegal_q;
  assign instr_retired = retired_q;

endmodule

// File: tb/tb_multi_cycle_control.sv
// Scoreboard bench for multi_cycle_control: each driven cycle pushes its
// expected state/outputs; a negedge monitor pops and compares.
module tb_multi_cycle_control;
  import mips_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        rst;
  logic [5:0]  opcode;
  logic        mem_ready;
  logic        pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write;
  logic        mem_to_reg, reg_dst, reg_write, alu_src_a, funct_ovr_en, illegal_op;
  logic [1:0]  alu_src_b, alu_op, pc_source;
  logic [5:0]  funct_ovr;
  logic [3:0]  state_o;
  logic [31:0] instr_retired;

  multi_cycle_control #(.RET_CNT_W(32), .OP_W(6)) dut (
    .clk(clk), .rst(rst), .opcode(opcode), .mem_ready(mem_ready),
    .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
    .mem_read(mem_read), .mem_write(mem_write), .ir_write(ir_write),
    .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .reg_write(reg_write),
    .alu_src_a(alu_src_a), .alu_src_b(alu_src_b), .alu_op(alu_op),
    .funct_ovr_en(funct_ovr_en), .funct_ovr(funct_ovr), .pc_source(pc_source),
    .state_o(state_o), .illegal_op(illegal_op), .instr_retired(instr_retired)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0]  st;
    logic [22:0] ctrl;
    logic [31:0] ret;
    logic        ill;
  } exp_t;

  exp_t        sb[$];
  exp_t        mon_e;
  int          n_checks = 0;
  int          n_errors = 0;
  int unsigned exp_ret;
  logic        exp_ill;
  logic [22:0] dut_ctrl;

  assign dut_ctrl = {pc_write, pc_write_cond, i_or_d, mem_read, mem_write, ir_write,
                     mem_to_reg, reg_dst, reg_write, alu_src_a, alu_src_b, alu_op,
                     funct_ovr_en, funct_ovr, pc_source};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Reference control word per state, written straight from the state table
  function automatic logic [22:0] exp_ctrl(input state_t s, input logic [5:0] op,
                                           input logic rdy, input logic r);
    logic pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, fe;
    logic [1:0] asb, aop, pcs;
    logic [5:0] fo;
    {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, fe} = '0;
    asb = 2'b00; aop = 2'b00; pcs = 2'b00; fo = 6'b000000;
    case (s)
      ST_FETCH:    begin mr = 1; asb = 2'b01; irw = rdy; pcw = rdy; end
      ST_DECODE:   asb = 2'b11;
      ST_MEM_ADDR: begin asa = 1; asb = 2'b10; end
      ST_MEM_RD:   begin mr = 1; iord = 1; end
      ST_MEM_WB:   begin rw = 1; m2r = 1; end
      ST_MEM_WR:   begin mw = 1; iord = 1; end
      ST_R_EXEC:   begin asa = 1; aop = 2'b10; end
      ST_R_WB:     begin rw = 1; rd = 1; end
      ST_I_EXEC: begin
        asa = 1; asb = 2'b10; aop = 2'b10; fe = 1;
        fo = (op == 6'b001000) ? 6'b100000 :
             (op == 6'b001100) ? 6'b100100 : 6'b100101;
      end
      ST_I_WB:     rw = 1;
      ST_BRANCH:   begin asa = 1; aop = 2'b01; pcwc = 1; pcs = 2'b01; end
      ST_JUMP:     begin pcw = 1; pcs = 2'b10; end
      default: ;
    endcase
    if (r) {pcw, pcwc, mr, mw, irw, rw} = '0;
    return {pcw, pcwc, iord, mr, mw, irw, m2r, rd, rw, asa, asb, aop, fe, fo, pcs};
  endfunction

  function automatic logic legal(input logic [5:0] op);
    return op inside {6'b000000, 6'b100011, 6'b101011, 6'b000100,
                      6'b000010, 6'b001000, 6'b001100, 6'b001101};
  endfunction

  // Drive one cycle: push its expectation, advance, update the bench model
  task automatic cyc(input state_t st, input logic [5:0] op, input logic rdy, input logic r);
    exp_t e;
    rst = r; opcode = op; mem_ready = rdy;
    e.st = st; e.ctrl = exp_ctrl(st, op, rdy, r); e.ret = exp_ret; e.ill = exp_ill;
    sb.push_back(e);
    @(posedge clk); #1;
    if (r) begin
      exp_ret = 0; exp_ill = 1'b0;
    end else begin
      exp_ill = (st == ST_DECODE) && !legal(op);
      if (st inside {ST_MEM_WB, ST_R_WB, ST_I_WB, ST_BRANCH, ST_JUMP} ||
          (st == ST_MEM_WR && rdy)) exp_ret++;
    end
  endtask

  function automatic logic rnd();
    return 1'($urandom_range(0, 1));
  endfunction

  // One full instruction with fw/mw wait cycles in FETCH and the memory state
  task automatic do_instr(input logic [5:0] op, input int fw, input int mw);
    for (int i = 0; i < fw; i++) cyc(ST_FETCH, op, 1'b0, 1'b0);
    cyc(ST_FETCH, op, 1'b1, 1'b0);
    cyc(ST_DECODE, op, rnd(), 1'b0);
    case (op)
      6'b000000: begin cyc(ST_R_EXEC, op, rnd(), 1'b0); cyc(ST_R_WB, op, rnd(), 1'b0); end
      6'b100011: begin
        cyc(ST_MEM_ADDR, op, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) cyc(ST_MEM_RD, op, 1'b0, 1'b0);
        cyc(ST_MEM_RD, op, 1'b1, 1'b0);
        cyc(ST_MEM_WB, op, rnd(), 1'b0);
      end
      6'b101011: begin
        cyc(ST_MEM_ADDR, op, rnd(), 1'b0);
        for (int i = 0; i < mw; i++) cyc(ST_MEM_WR, op, 1'b0, 1'b0);
        cyc(ST_MEM_WR, op, 1'b1, 1'b0);
      end
      6'b000100: cyc(ST_BRANCH, op, rnd(), 1'b0);
      6'b000010: cyc(ST_JUMP, op, rnd(), 1'b0);
      6'b001000, 6'b001100, 6'b001101: begin
        cyc(ST_I_EXEC, op, rnd(), 1'b0); cyc(ST_I_WB, op, rnd(), 1'b0);
      end
      default: ;
    endcase
    $display("instr op=%b fw=%0d mw=%0d retired_exp=%0d", op, fw, mw, exp_ret);
  endtask

  // Monitor: compare one scoreboard entry per cycle, away from the clock edge
  always @(negedge clk) begin
    if (sb.size() > 0) begin
      mon_e = sb.pop_front();
      check("state",   {28'd0, state_o},      {28'd0, mon_e.st});
      check("ctrl",    {9'd0, dut_ctrl},      {9'd0, mon_e.ctrl});
      check("retired", instr_retired,         mon_e.ret);
      check("illegal", {31'd0, illegal_op},   {31'd0, mon_e.ill});
    end
  end

  initial begin
    rst = 1'b1; opcode = 6'd0; mem_ready = 1'b0;
    exp_ret = 0; exp_ill = 1'b0;
    @(posedge clk); #1;
    cyc(ST_FETCH, 6'd0, 1'b1, 1'b1);          // second reset cycle, writes gated

    do_instr(6'b000000, 0, 0);                 // add
    do_instr(6'b100011, 3, 3);                 // lw with memory stalls
    do_instr(6'b001101, 0, 0);                 // ori
    do_instr(6'b000100, 0, 0);                 // beq
    do_instr(6'b000010, 0, 0);                 // j
    do_instr(6'b111111, 0, 0);                 // illegal
    do_instr(6'b001000, 1, 0);                 // addi
    do_instr(6'b001100, 0, 0);                 // andi
    do_instr(6'b101011, 0, 2);                 // sw with stall
    do_instr(6'b010001, 0, 0);                 // another illegal

    // Reset while a store is stalled: no write, back to FETCH, counter cleared
    cyc(ST_FETCH, 6'b101011, 1'b1, 1'b0);
    cyc(ST_DECODE, 6'b101011, 1'b0, 1'b0);
    cyc(ST_MEM_ADDR, 6'b101011, 1'b0, 1'b0);
    cyc(ST_MEM_WR, 6'b101011, 1'b0, 1'b0);
    cyc(ST_MEM_WR, 6'b101011, 1'b0, 1'b1);
    $display("reset during sw stall, retired_exp=%0d", exp_ret);
    do_instr(6'b000000, 0, 0);                 // add after reset

    @(negedge clk);
    check("sb_empty", sb.size(), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
